chirp_source: RTL and testbench
===============================

// Module: chirp_source
// PURPOSE
//  Linear-FM (chirp) stimulus source feeding systolicFilter's Data_i/DataNd_i.
//  Phase accumulator plus linearly ramped phase increment drive a quarter-wave sine LUT.
//  Emits 18-bit signed samples at amplitude 2^16 full-scale.
//  Holds DataNd_o high with zero data while idle, so the downstream filter pipeline keeps flushing.
// PARAMETERS
//  RATE_DIV    1   clocks per sample strobe (1 = one sample every clock)
//  PHASE_W     32  phase accumulator / increment width
//  LUT_ADDR_W  10  quarter-wave LUT address width (1024 entries)
//  CNT_W       24  sample-length counter width
// PORTS
//  Clk_i            in   1   clock
//  Rst_i            in   1   synchronous reset, active-high
//  Start_i          in   1   start chirp; latches PhaseIncStart_i, PhaseIncStep_i, Length_i
//  Stop_i           in   1   abort running chirp
//  PhaseIncStart_i  in   32  initial phase increment (unsigned, cycles = inc/2^32 per sample)
//  PhaseIncStep_i   in   32  increment added to phase increment each sample
//  Length_i         in   24  chirp length in samples; 0 = run until Stop_i
//  Data_o           out  18  signed sample to systolicFilter Data_i
//  DataNd_o         out  1   new-data strobe to systolicFilter DataNd_i
//  Busy_o           out  1   high in RUN and FLUSH
//  Done_o           out  1   one-cycle pulse on return to IDLE
// BEHAVIOUR
//  - Reset: Data_o=0, DataNd_o=0, Busy_o=0, Done_o=0, state=IDLE, phase=0, inc=0, cnt=0, rate cnt=0.
//  - Strobe: rate counter counts 0..RATE_DIV-1; strobe on terminal count, every state.
//  - IDLE: each strobe gives Data_o=0 with DataNd_o=1, at the same 2-cycle latency as RUN.
//  - IDLE, Start_i=1 and Stop_i=0: latch inputs, phase=0, inc=PhaseIncStart_i, cnt=0, go to RUN.
//  - IDLE, Start_i and Stop_i together: stay IDLE.
//  - RUN, per strobe:
//      sample phase;
//      phase <= phase + inc (mod 2^32);
//      inc <= min(inc + step, 32'h7FFF_FFFF), saturating at Nyquist, no wrap;
//      cnt++.
//  - RUN -> FLUSH: Stop_i=1, or cnt reaches Length_i (Length_i != 0) after the last sample is issued.
//  - RUN: Start_i is ignored.
//  - FLUSH: 2 cycles to drain the LUT pipeline, then IDLE with Done_o=1 for 1 cycle.
//    Strobes during FLUSH output 0.
//  - Latency: strobe in cycle n -> Data_o/DataNd_o valid in cycle n+2.
//    DataNd_o is high for exactly 1 cycle per strobe; Data_o holds its value between strobes.
//  - Sine lookup:
//      q = phase[31:30]; a = phase[29:20];
//      q odd -> address ~a (mirror);
//      q >= 2 -> negate (two's complement, 18 bit).
//  - LUT[k] = round(65535*sin(pi/2*(k+0.5)/1024)).
//    Range 50..65535; output range -65535..+65535; never overflows 18 bits.
//  - Rst_i mid-chirp: immediate return to reset values; in-flight pipeline samples discarded (DataNd_o=0).
// STRUCTURE
//  - Shared package/include (systolic_pkg):
//      DATA_W=18, PHASE_W=32, AMPL=65535;
//      state encodings IDLE/RUN/FLUSH; INC_MAX=32'h7FFF_FFFF.
//  - Sub-module chirp_sine_lut: registered quarter-wave ROM, 1024x17, generated by initial-block
//    $sin (sim) / init file (synth).
//  - Top holds rate counter, FSM, accumulators, quadrant/sign pipeline register.
// TESTING
//  - Reset, idle 10 clocks (RATE_DIV=1) -> DataNd_o=1 every clock from cycle 2, Data_o=0, Busy_o=0.
//  - Start, PhaseIncStart=0x4000_0000, step=0, Length=4 ->
//      Data_o = 50, 65535, -50 (0x3FFCE), -65535 (0x30001);
//      then Done_o pulse 2 cycles after the last sample;
//      Busy_o high for 4+2 cycles.
//  - PhaseIncStart=0x7FFF_FF00, step=0x100, Length=8 -> inc saturates at 0x7FFF_FFFF from sample 2.
//    Output alternates sign; no wrap to a negative/low increment.
//  - Length=0, Start, Stop after 100 samples -> exactly 100 nonzero-phase samples, FLUSH, Done_o.
//    Start_i pulses during RUN ignored.
//  - Rst_i asserted in the middle of RUN -> next cycle all outputs at reset values; no further DataNd_o.
//    A new Start restarts from phase=0.
//  - RATE_DIV=4, chirp inc 0x0010_0000, step 0x1000 ->
//      DataNd_o every 4th clock;
//      samples match a $sin reference model within +/-1 LSB;
//      systolicFilter accepts the stream.

Source files
------------

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared constants for the systolic filter stimulus path
// Sample width, FSM encodings and the quarter-wave sine table generator.
package systolic_pkg;
  localparam int DATA_W  = 18;
  localparam int PHASE_W = 32;
  localparam int AMPL    = 65535;
  localparam logic [31:0] INC_MAX = 32'h7FFF_FFFF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam longint PI_HALF_Q28 = 64'sd421657428;

  // Q28 Taylor series; entry k is sampled at (k+0.5) steps so neither 0 nor the peak repeats
  function automatic logic [DATA_W-2:0] sine_entry(input int k, input int addr_w);
    longint x, x2, term, acc;
    x    = (PI_HALF_Q28 * longint'(2 * k + 1)) >>> (addr_w + 1);
    x2   = (x * x) >>> 28;
    term = x;
    acc  = x;
    for (int n = 1; n <= 8; n++) begin
      term = -((term * x2) >>> 28) / longint'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    return (DATA_W-1)'((longint'(AMPL) * acc + (longint'(1) <<< 27)) >>> 28);
  endfunction
endpackage

// File: rtl/chirp_sine_lut.sv
// rtl/chirp_sine_lut.sv - registered quarter-wave sine ROM
// Contents are elaborated from sine_entry, so no init file or initial block is needed.
module chirp_sine_lut
  import systolic_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                clk_i,
  input  logic [ADDR_W-1:0]   addr_i,
  output logic [DATA_W-2:0]   data_o
);

  logic [DATA_W-2:0] rom [2**ADDR_W];
  logic [DATA_W-2:0] data_d;
  logic [DATA_W-2:0] data_q;

  for (genvar k = 0; k < 2**ADDR_W; k++) begin : g_rom
    localparam logic [DATA_W-2:0] ENTRY = sine_entry(k, ADDR_W);
    assign rom[k] = ENTRY;
  end

  always_comb begin
    data_d = rom[addr_i];
  end

  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/chirp_source.sv
// rtl/chirp_source.sv - linear-FM chirp source for the systolic filter input
// Rate strobe, IDLE/RUN/FLUSH control, phase/increment accumulators and a 2-stage sine pipeline.
module chirp_source #(
  parameter int RATE_DIV   = 1,
  parameter int PHASE_W    = systolic_pkg::PHASE_W,
  parameter int LUT_ADDR_W = 10,
  parameter int CNT_W      = 24
) (
  input  logic                            Clk_i,
  input  logic                            Rst_i,
  input  logic                            Start_i,
  input  logic                            Stop_i,
  input  logic [PHASE_W-1:0]              PhaseIncStart_i,
  input  logic [PHASE_W-1:0]              PhaseIncStep_i,
  input  logic [CNT_W-1:0]                Length_i,
  output logic [systolic_pkg::DATA_W-1:0] Data_o,
  output logic                            DataNd_o,
  output logic                            Busy_o,
  output logic                            Done_o
);

  localparam int DW     = systolic_pkg::DATA_W;
  localparam int RATE_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [RATE_W-1:0]  RATE_LAST = RATE_W'(RATE_DIV - 1);
  localparam logic [PHASE_W-1:0] INC_LIMIT = {1'b0, {(PHASE_W-1){1'b1}}};

  logic [RATE_W-1:0]  rate_q, rate_d;
  logic [1:0]         state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] inc_q, inc_d;
  logic [PHASE_W-1:0] step_q, step_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               flush_q, flush_d;
  logic               done_q, done_d;
  logic               s1_nd_q, s1_nd_d;
  logic               s1_zero_q, s1_zero_d;
  logic               s1_neg_q, s1_neg_d;
  logic [DW-1:0]      data_q, data_d;
  logic               nd_q, nd_d;

  logic                  strobe;
  logic                  take_sample;
  logic [PHASE_W:0]      inc_sum;
  logic [CNT_W-1:0]      cnt_inc;
  logic [LUT_ADDR_W-1:0] lut_addr;
  logic [DW-2:0]         lut_data;
  logic [DW-1:0]         mag;

  chirp_sine_lut #(
    .ADDR_W (LUT_ADDR_W)
  ) u_lut (
    .clk_i  (Clk_i),
    .addr_i (lut_addr),
    .data_o (lut_data)
  );

  always_comb begin
    strobe      = (rate_q == RATE_LAST);
    rate_d      = strobe ? '0 : rate_q + 1'b1;
    state_d     = state_q;
    phase_d     = phase_q;
    inc_d       = inc_q;
    step_d      = step_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    flush_d     = flush_q;
    done_d      = 1'b0;
    take_sample = 1'b0;
    inc_sum     = {1'b0, inc_q} + {1'b0, step_q};
    cnt_inc     = cnt_q + 1'b1;

    case (state_q)
      systolic_pkg::ST_IDLE: begin
        if (Start_i && !Stop_i) begin
          state_d = systolic_pkg::ST_RUN;
          phase_d = '0;
          inc_d   = PhaseIncStart_i;
          step_d  = PhaseIncStep_i;
          len_d   = Length_i;
          cnt_d   = '0;
        end
      end
      systolic_pkg::ST_RUN: begin
        if (Stop_i) begin
          state_d = systolic_pkg::ST_FLUSH;
          flush_d = 1'b0;
        end else if (strobe) begin
          take_sample = 1'b1;
          phase_d     = phase_q + inc_q;
          inc_d       = (inc_sum > {1'b0, INC_LIMIT}) ? INC_LIMIT : inc_sum[PHASE_W-1:0];
          cnt_d       = cnt_inc;
          if ((len_q != '0) && (cnt_inc == len_q)) begin
            state_d = systolic_pkg::ST_FLUSH;
            flush_d = 1'b0;
          end
        end
      end
      systolic_pkg::ST_FLUSH: begin
        if (flush_q) begin
          state_d = systolic_pkg::ST_IDLE;
          done_d  = 1'b1;
        end else begin
          flush_d = 1'b1;
        end
      end
      default: state_d = systolic_pkg::ST_IDLE;
    endcase

    // odd quadrants walk the quarter wave backwards, upper half-cycle is negated
    lut_addr  = phase_q[PHASE_W-2] ? ~phase_q[PHASE_W-3 -: LUT_ADDR_W]
                                   :  phase_q[PHASE_W-3 -: LUT_ADDR_W];
    s1_nd_d   = strobe;
    s1_zero_d = !take_sample;
    s1_neg_d  = phase_q[PHASE_W-1];

    mag    = {1'b0, lut_data};
    data_d = data_q;
    if (s1_nd_q) begin
      data_d = s1_zero_q ? '0 : (s1_neg_q ? -mag : mag);
    end
    nd_d = s1_nd_q;
  end

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      rate_q    <= '0;
      state_q   <= systolic_pkg::ST_IDLE;
      phase_q   <= '0;
      inc_q     <= '0;
      step_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      flush_q   <= 1'b0;
      done_q    <= 1'b0;
      s1_nd_q   <= 1'b0;
      s1_zero_q <= 1'b1;
      s1_neg_q  <= 1'b0;
      data_q    <= '0;
      nd_q      <= 1'b0;
    end else begin
      rate_q    <= rate_d;
      state_q   <= state_d;
      phase_q   <= phase_d;
      inc_q     <= inc_d;
      step_q    <= step_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      flush_q   <= flush_d;
      done_q    <= done_d;
      s1_nd_q   <= s1_nd_d;
      s1_zero_q <= s1_zero_d;
      s1_neg_q  <= s1_neg_d;
      data_q    <= data_d;
      nd_q      <= nd_d;
    end
  end

  assign Data_o   = data_q;
  assign DataNd_o = nd_q;
  assign Busy_o   = (state_q == systolic_pkg::ST_RUN) || (state_q == systolic_pkg::ST_FLUSH);
  assign Done_o   = done_q;

endmodule

// File: tb/tb_chirp_source.sv
// tb/tb_chirp_source.sv - directed self-checking bench for chirp_source
// Two instances: RATE_DIV=1 for the control/latency checks, RATE_DIV=4 for the decimated chirp.
module tb_chirp_source;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, start = 1'b0, stop = 1'b0;
  logic        rst4 = 1'b1, start4 = 1'b0, stop4 = 1'b0;
  logic [31:0] inc_start = '0, inc_step = '0;
  logic [23:0] length = '0;
  logic [17:0] data1, data4;
  logic        nd1, busy1, done1, nd4, busy4, done4;

  chirp_source #(.RATE_DIV(1)) dut1 (
    .Clk_i(clk), .Rst_i(rst), .Start_i(start), .Stop_i(stop),
    .PhaseIncStart_i(inc_start), .PhaseIncStep_i(inc_step), .Length_i(length),
    .Data_o(data1), .DataNd_o(nd1), .Busy_o(busy1), .Done_o(done1)
  );

  chirp_source #(.RATE_DIV(4)) dut4 (
    .Clk_i(clk), .Rst_i(rst4), .Start_i(start4), .Stop_i(stop4),
    .PhaseIncStart_i(inc_start), .PhaseIncStep_i(inc_step), .Length_i(length),
    .Data_o(data4), .DataNd_o(nd4), .Busy_o(busy4), .Done_o(done4)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic signed [17:0] s1[$];
  logic signed [17:0] s4[$];
  int c4[$];

  always @(negedge clk) begin
    cyc++;
    if (nd1 && data1 != '0) s1.push_back(data1);
    if (nd4) c4.push_back(cyc);
    if (nd4 && data4 != '0) s4.push_back(data4);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int ref_sample(input logic [31:0] ph);
    logic [9:0] a;
    real        m;
    int         mag;
    a   = ph[30] ? ~ph[29:20] : ph[29:20];
    m   = 65535.0 * $sin(3.14159265358979 / 2.0 * (real'(a) + 0.5) / 1024.0);
    mag = $rtoi(m + 0.5);
    return ph[31] ? -mag : mag;
  endfunction

  // Length=4 chirp, one quadrant per sample; index i is the i-th negedge after Start is taken
  task automatic run_quadrants(input string tag);
    logic [17:0] exp_d [8];
    logic        exp_b [8];
    logic        exp_dn [8];
    exp_d  = '{18'h0, 18'h0, 18'h00032, 18'h0FFFF, 18'h3FFCE, 18'h30001, 18'h0, 18'h0};
    exp_b  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_dn = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    inc_start = 32'h4000_0000;
    inc_step  = 32'h0;
    length    = 24'd4;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_data%0d", tag, i), data1, exp_d[i]);
      chk($sformatf("%s_nd%0d", tag, i), nd1, 1'b1);
      chk($sformatf("%s_busy%0d", tag, i), busy1, exp_b[i]);
      chk($sformatf("%s_done%0d", tag, i), done1, exp_dn[i]);
      tick(1);
    end
  endtask

  initial begin
    int t;
    int bad;
    logic [31:0] ph;
    logic [31:0] inc;
    logic [17:0] exp_sat [8];

    // reset and idle flushing
    tick(3);
    chk("rst_nd", nd1, 1'b0);
    chk("rst_data", data1, 18'h0);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_done", done1, 1'b0);
    rst = 1'b0;
    tick(1);
    chk("idle_nd_c0", nd1, 1'b0);
    tick(1);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("idle_nd%0d", i), nd1, 1'b1);
      chk($sformatf("idle_data%0d", i), data1, 18'h0);
      chk($sformatf("idle_busy%0d", i), busy1, 1'b0);
      tick(1);
    end

    // Start together with Stop stays idle
    start = 1'b1;
    stop  = 1'b1;
    tick(1);
    start = 1'b0;
    stop  = 1'b0;
    chk("startstop_busy", busy1, 1'b0);
    tick(2);

    run_quadrants("quad");
    tick(2);

    // increment saturation at Nyquist
    exp_sat = '{18'h00032, 18'h00032, 18'h3FFCE, 18'h00032,
                18'h3FFCE, 18'h00032, 18'h3FFCE, 18'h00032};
    inc_start = 32'h7FFF_FF00;
    inc_step  = 32'h0000_0100;
    length    = 24'd8;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("sat_data%0d", i), data1, exp_sat[i]);
      tick(1);
    end
    chk("sat_done", done1, 1'b1);
    tick(3);

    // open-ended chirp, Start ignored in RUN, Stop after 100 samples
    s1.delete();
    inc_start = 32'h0100_0000;
    inc_step  = 32'h0;
    length    = 24'd0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      tick(1);
      start = (i == 20 || i == 50);
      stop  = (i == 100);
    end
    tick(1);
    start = 1'b0;
    stop  = 1'b0;
    t = 0;
    while (!done1 && t < 20) begin
      tick(1);
      t++;
    end
    chk("stop_done", done1, 1'b1);
    tick(3);
    chk("stop_count", s1.size(), 100);
    bad = 0;
    for (int k = 0; k < s1.size() && k < 100; k++) begin
      ph = 32'(k) << 24;
      if (int'(s1[k]) - ref_sample(ph) > 1 || ref_sample(ph) - int'(s1[k]) > 1) bad++;
    end
    chk("stop_model", bad, 0);

    // synchronous reset in the middle of RUN
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(10);
    chk("midrst_busy_pre", busy1, 1'b1);
    rst = 1'b1;
    tick(1);
    chk("midrst_nd", nd1, 1'b0);
    chk("midrst_data", data1, 18'h0);
    chk("midrst_busy", busy1, 1'b0);
    chk("midrst_done", done1, 1'b0);
    tick(1);
    chk("midrst_nd2", nd1, 1'b0);
    rst = 1'b0;
    tick(1);
    chk("midrst_nd3", nd1, 1'b0);
    tick(1);
    chk("midrst_nd4", nd1, 1'b1);
    chk("midrst_data4", data1, 18'h0);
    tick(2);
    run_quadrants("restart");

    // RATE_DIV=4 chirp against the sine model
    inc_start = 32'h0010_0000;
    inc_step  = 32'h0000_1000;
    length    = 24'd16;
    s4.delete();
    c4.delete();
    rst4 = 1'b0;
    tick(3);
    start4 = 1'b1;
    tick(1);
    start4 = 1'b0;
    t = 0;
    while (!done4 && t < 300) begin
      tick(1);
      t++;
    end
    chk("div4_done", done4, 1'b1);
    tick(8);
    chk("div4_count", s4.size(), 16);
    bad = 0;
    ph  = 32'h0;
    inc = 32'h0010_0000;
    for (int k = 0; k < s4.size() && k < 16; k++) begin
      if (int'(s4[k]) - ref_sample(ph) > 1 || ref_sample(ph) - int'(s4[k]) > 1) bad++;
      ph  = ph + inc;
      inc = inc + 32'h0000_1000;
    end
    chk("div4_model", bad, 0);
    bad = 0;
    for (int i = 1; i < c4.size(); i++) begin
      if (c4[i] - c4[i-1] != 4) bad++;
    end
    chk("div4_gaps", bad, 0);
    chk("div4_strobes", (c4.size() >= 16), 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
